seg7_scan_driver: RTL and testbench

- Parametrised multi-digit, time-multiplexed 7-segment display driver for the alarm clock display path.
- Takes a packed vector of 4-bit digit codes and latches a tear-free snapshot once per scan frame.
- Scans one digit per scan tick and adds the following per digit: optional hex glyphs, leading-zero suppression, decimal points, per-digit blanking and per-digit blinking.

---
 rtl/seg7_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: latches a frame snapshot, one digit per scan slot.
// Latency: outputs registered, follow the digit index by one clock; no backpressure.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int HEX_EN         = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  lz_en,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRE_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [FRM_W-1:0]    r_frm;
    logic                r_phase;
    logic [4*DIGITS-1:0] r_snap_dig;
    logic [DIGITS-1:0]   r_snap_dp;
    logic [DIGITS-1:0]   r_snap_blank;
    logic [DIGITS-1:0]   r_snap_blink;
    logic                r_snap_lz;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_wrap;
    logic [3:0]          w_codes [DIGITS];
    logic [3:0]          w_code;
    logic [DIGITS-1:0]   w_zero_hi;
    logic                w_run;
    logic                w_blank;
    logic                w_supp;
    logic                w_dp_req;
    logic                w_show;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_seg_nxt;
    logic                w_dp_nxt;
    logic [DIGITS-1:0]   w_an_nxt;

    function automatic logic [6:0] f_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1111011;
            4'd10:   g = 7'b1110111;
            4'd11:   g = 7'b0011111;
            4'd12:   g = 7'b1001110;
            4'd13:   g = 7'b0111101;
            4'd14:   g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        if (HEX_EN == 0 && code >= 4'd10) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    assign w_tick = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_idx == IDX_W'(DIGITS - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_codes
        assign w_codes[g] = r_snap_dig[4*g +: 4];
    end

    // w_zero_hi[k]: digit k and every more-significant digit are zero
    always_comb begin
        w_run     = 1'b1;
        w_zero_hi = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_run        = w_run & (w_codes[k] == 4'd0);
            w_zero_hi[k] = w_run;
        end
    end

    always_comb begin
        w_code    = w_codes[r_idx];
        w_blank   = r_snap_blank[r_idx] | (r_snap_blink[r_idx] & r_phase);
        w_supp    = r_snap_lz & w_zero_hi[r_idx];
        w_dp_req  = r_snap_dp[r_idx];
        // a suppressed zero keeps its anode only to light a requested decimal point
        w_show    = ~w_blank & ~(w_supp & ~w_dp_req);
        w_onehot  = DIGITS'(1) << r_idx;
        w_an_nxt  = w_show ? w_onehot : '0;
        w_seg_nxt = (w_show & ~w_supp) ? f_glyph(w_code) : 7'b0000000;
        w_dp_nxt  = w_show & w_dp_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frm        <= '0;
            r_phase      <= 1'b0;
            r_snap_dig   <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_snap_blink <= '0;
            r_snap_lz    <= 1'b0;
            r_seg        <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end
            if (w_wrap) begin
                r_snap_dig   <= digits_in;
                r_snap_dp    <= dp_in;
                r_snap_blank <= blank_in;
                r_snap_blink <= blink_in;
                r_snap_lz    <= lz_en;
                if (r_frm == FRM_W'(BLINK_FRAMES - 1)) begin
                    r_frm   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_frm <= r_frm + 1'b1;
                end
            end
            r_seg <= w_seg_nxt ^ SEG_OFF;
            r_dp  <= w_dp_nxt ^ DP_OFF;
            r_an  <= w_an_nxt ^ AN_OFF;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign an_out     = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (hex/active-high and no-hex/active-low segments)
// compared every cycle against a frame-arithmetic model, plus literal spot values.
module tb_seg7_scan_driver;

    localparam int D     = 4;
    localparam int S     = 4;
    localparam int BF    = 2;
    localparam int FRAME = S * D;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in, blank_in, blink_in;
    logic        lz_en;
    logic [6:0]  seg_out, seg2;
    logic        dp_out, dp2;
    logic [3:0]  an_out, an2;
    logic        frame_done, fd2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLINK_FRAMES(BF), .HEX_EN(1),
                       .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .blink_in(blink_in), .lz_en(lz_en), .seg_out(seg_out), .dp_out(dp_out),
        .an_out(an_out), .frame_done(frame_done));

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLINK_FRAMES(BF), .HEX_EN(0),
                       .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .blink_in(blink_in), .lz_en(lz_en), .seg_out(seg2), .dp_out(dp2),
        .an_out(an2), .frame_done(fd2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [6:0]  glyph_tab [16];
    bit          started = 0;
    int          n = 0;             // clean edges since the last reset edge
    logic [15:0] sc_dig, sp_dig;
    logic [3:0]  sc_dp, sc_blank, sc_blink, sp_dp, sp_blank, sp_blink;
    logic        sc_lz, sp_lz;

    initial begin
        glyph_tab[0]  = 7'b1111110; glyph_tab[1]  = 7'b0110000; glyph_tab[2]  = 7'b1101101;
        glyph_tab[3]  = 7'b1111001; glyph_tab[4]  = 7'b0110011; glyph_tab[5]  = 7'b1011011;
        glyph_tab[6]  = 7'b1011111; glyph_tab[7]  = 7'b1110000; glyph_tab[8]  = 7'b1111111;
        glyph_tab[9]  = 7'b1111011; glyph_tab[10] = 7'b1110111; glyph_tab[11] = 7'b0011111;
        glyph_tab[12] = 7'b1001110; glyph_tab[13] = 7'b0111101; glyph_tab[14] = 7'b1001111;
        glyph_tab[15] = 7'b1000111;
    end

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            n = 0;
            sc_dig = 0; sc_dp = 0; sc_blank = 0; sc_blink = 0; sc_lz = 0;
            sp_dig = 0; sp_dp = 0; sp_blank = 0; sp_blink = 0; sp_lz = 0;
        end else if (started) begin
            n++;
            sp_dig = sc_dig; sp_dp = sc_dp; sp_blank = sc_blank; sp_blink = sc_blink; sp_lz = sc_lz;
            if (n % FRAME == 0) begin
                sc_dig = digits_in; sc_dp = dp_in; sc_blank = blank_in;
                sc_blink = blink_in; sc_lz = lz_en;
            end
        end
    end

    // display produced from the state m clean edges after reset
    function automatic void model_out(input int m, input bit hex_en, input bit seg_al,
                                      output logic [6:0] seg, output logic dp, output logic [3:0] an);
        int         idx = (m / S) % D;
        int         fr  = m / FRAME;
        bit         ph  = ((fr / BF) % 2) == 1;
        logic [3:0] code = sp_dig[4*idx +: 4];
        logic [6:0] glyph = glyph_tab[code];
        bit         supp = 0;
        bit         blank;
        if (!hex_en && code >= 10) glyph = 0;
        if (sp_lz && idx >= 1) begin
            supp = 1;
            for (int k = idx; k < D; k++) if (sp_dig[4*k +: 4] != 0) supp = 0;
        end
        blank = sp_blank[idx] || (sp_blink[idx] && ph);
        seg = 0; dp = 0; an = 0;
        if (!blank && !(supp && !sp_dp[idx])) begin
            an = 4'(1 << idx);
            dp = sp_dp[idx];
            if (!supp) seg = glyph;
        end
        if (seg_al) begin seg = ~seg; dp = ~dp; end
        an = ~an;
    endfunction

    logic [6:0] e_seg, e2_seg;
    logic       e_dp, e2_dp, e_fd;
    logic [3:0] e_an, e2_an;

    always @(negedge clk) begin
        if (started) begin
            if (n == 0) begin
                e_seg = 7'h00; e_dp = 1'b0; e_an = 4'hF;
                e2_seg = 7'h7F; e2_dp = 1'b1; e2_an = 4'hF;
                e_fd = 1'b0;
            end else begin
                model_out(n - 1, 1'b1, 1'b0, e_seg, e_dp, e_an);
                model_out(n - 1, 1'b0, 1'b1, e2_seg, e2_dp, e2_an);
                e_fd = (n % FRAME == 0);
            end
            chk("model_seg", seg_out, e_seg);
            chk("model_dp", dp_out, e_dp);
            chk("model_an", an_out, e_an);
            chk("model_fd", frame_done, e_fd);
            chk("model2_seg", seg2, e2_seg);
            chk("model2_dp", dp2, e2_dp);
            chk("model2_an", an2, e2_an);
            chk("model2_fd", fd2, e_fd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_fd();
        bit got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) got = 1;
        end
        if (!got) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        bit vis [4];
        int vis_cnt;
        rst = 1'b1; digits_in = 16'h1234; dp_in = 0; blank_in = 0; blink_in = 0; lz_en = 0;
        step(2);
        chk("rst_an", an_out, 4'b1111);
        chk("rst_seg", seg_out, 7'b0000000);
        chk("rst_seg_al", seg2, 7'b1111111);
        chk("rst_fd", frame_done, 0);
        rst = 1'b0;

        // basic scan of 1234
        step(15); chk("fd_low_n15", frame_done, 0);
        step(1);  chk("fd_high_n16", frame_done, 1);
        step(1);  chk("d0_four", seg_out, 7'b0110011); chk("d0_an", an_out, 4'b1110);
        chk("fd_one_cycle", frame_done, 0);
        step(4);  chk("d1_three", seg_out, 7'b1111001); chk("d1_an", an_out, 4'b1101);

        // leading-zero suppression
        digits_in = 16'h0070; lz_en = 1;
        wait_fd();
        step(1);  chk("lz_d0", seg_out, 7'b1111110); chk("lz_d0_an", an_out, 4'b1110);
        step(4);  chk("lz_d1", seg_out, 7'b1110000); chk("lz_d1_an", an_out, 4'b1101);
        step(4);  chk("lz_d2_an", an_out, 4'b1111);
        step(4);  chk("lz_d3_an", an_out, 4'b1111);
        dp_in = 4'b0100;
        wait_fd();
        step(9);  chk("lzdp_an", an_out, 4'b1011); chk("lzdp_seg", seg_out, 0); chk("lzdp_dp", dp_out, 1);

        // hex glyphs
        digits_in = 16'hABCD; lz_en = 0; dp_in = 0;
        wait_fd();
        step(1);  chk("hex_d", seg_out, 7'b0111101); chk("nohex_d", seg2, 7'b1111111);
        step(4);  chk("hex_C", seg_out, 7'b1001110); chk("nohex_C", seg2, 7'b1111111);
        step(4);  chk("hex_b", seg_out, 7'b0011111);
        step(4);  chk("hex_A", seg_out, 7'b1110111); chk("hex_A_an", an_out, 4'b0111);

        // blink digit 0 over four consecutive frames
        digits_in = 16'h1234; blink_in = 4'b0001;
        wait_fd();
        step(1);
        vis_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            vis[f] = (an_out[0] == 1'b0);
            if (vis[f]) vis_cnt++;
            if (f < 3) step(16);
        end
        chk("blink_visible_frames", vis_cnt, 2);
        chk("blink_pair_a", vis[0] != vis[2], 1);
        chk("blink_pair_b", vis[1] != vis[3], 1);
        blink_in = 0;

        // snapshot integrity
        digits_in = 16'h1111;
        wait_fd();
        step(1);  chk("snap_d0", seg_out, 7'b0110000);
        step(4);  digits_in = 16'h2222; chk("snap_d1", seg_out, 7'b0110000);
        step(4);  chk("snap_d2", seg_out, 7'b0110000);
        step(4);  chk("snap_d3", seg_out, 7'b0110000);
        step(4);  chk("snap_next", seg_out, 7'b1101101); chk("snap_next_an", an_out, 4'b1110);

        // active-low segments on an eight
        digits_in = 16'h8888;
        wait_fd();
        step(1);  chk("al_eight", seg2, 7'b0000000); chk("ah_eight", seg_out, 7'b1111111);

        // reset while digit 2 is being scanned
        wait_fd();
        step(9);
        rst = 1'b1; step(1); rst = 1'b0;
        step(1);
        chk("mrst_seg", seg_out, 7'b1111110); chk("mrst_an", an_out, 4'b1110);
        chk("mrst_dp", dp_out, 0); chk("mrst_seg_al", seg2, 7'b0000001);

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) begin
                digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp_in     = 4'($urandom);
                blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
                blink_in  = 4'($urandom);
                lz_en     = 1'($urandom);
            end
        end
        rst = 1'b0;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
